ibex_core_event_recorder: RTL and testbench
===========================================

Name: ibex_core_event_recorder

Overview:
Sits directly downstream of the core's architectural event signals: illegal instruction, ecall, wfi, ebreak, dret, mret, core sleep and privilege mode.
Turns per-cycle event pulses into timestamped records and buffers them in a small FIFO. Records drain over a valid/ready stream towards trace/debug logic.
Overflow is counted, and the next record that fits is flagged as following a loss.

Parameters:
Depth, 8, FIFO entries; power of two, >= 2
TsW, 16, timestamp counter width; 8..32
DropW, 8, drop counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  recording enable; when 0 no pushes occur, but the timestamp still runs
clear_i  in  1  synchronous flush of FIFO, drop counter, lost flag and timestamp
illegal_instr_i  in  1  illegal instruction pulse
ecall_i  in  1  ecall pulse
wfi_i  in  1  wfi pulse
ebreak_i  in  1  ebreak pulse
dret_i  in  1  dret pulse
mret_i  in  1  mret pulse
core_sleep_i  in  1  core sleep level
priv_mode_i  in  2  ibex_pkg::priv_lvl_e, current privilege
rec_valid_o  out  1  head record valid
rec_ready_i  in  1  consumer ready
rec_o  out  11+TsW  head record, ibex_event_rec_pkg::event_rec_t
drop_cnt_o  out  DropW  records dropped since reset/clear, saturating
fifo_level_o  out  $clog2(Depth)+1  occupancy

Behaviour:
- Reset (rst_ni low, async) and clear_i:
  - rec_valid_o=0, rec_o=0, drop_cnt_o=0, fifo_level_o=0.
  - Timestamp=0, lost flag=0, sleep_q=0, priv_q=PRIV_LVL_M.
  - clear_i has priority over all same-cycle push/pop.
- Timestamp: free-running TsW counter, +1 every cycle, wraps to 0 silently.
- Event mask, 8 bits, computed per cycle:
  - bits 0..5: illegal, ecall, wfi, ebreak, dret, mret.
  - bit 6: sleep_entry = core_sleep_i & ~sleep_q.
  - bit 7: sleep_exit = ~core_sleep_i & sleep_q.
- Push request = enable_i & (mask != 0 | priv_mode_i != priv_q).
  - priv_q and sleep_q update every cycle regardless of enable_i.
  - Disabling therefore does not cause a spurious record on re-enable.
- Record fields, MSB to LSB: lost (1), priv (2, current priv_mode_i), mask (8), ts (TsW, timestamp value in the sampling cycle).
- Latency: a record for the cycle-t sample is written at edge t+1. rec_valid_o rises in cycle t+1 if the FIFO was empty. There is no combinational bypass.
- Pop: when rec_valid_o & rec_ready_i at an edge, the head advances. rec_o is stable while valid & ~ready.
- Full:
  - A push when level==Depth and no pop that cycle is dropped.
  - The drop increments drop_cnt (saturating at all-ones) and sets the lost flag.
- Full with a same-cycle pop: the push is accepted and the level stays Depth.
- Empty with push only: level becomes 1, rec_valid_o rises next cycle.
- Lost flag:
  - Written into the lost bit of the next accepted record.
  - Cleared in the same edge that record is accepted.
  - If a drop and an accept coincide (impossible by construction), drop wins.
- Pointers are $clog2(Depth) bits and wrap naturally; level is tracked separately.
- Multiple events in one cycle produce one record with multiple mask bits set.

Decomposition:
- ibex_event_rec_pkg contains:
  - event bit index constants EV_ILLEGAL=0 .. EV_SLEEP_EXIT=7, EV_W=8.
  - event_rec_t parameterised by TsW, via the package-level default TsW=16 and a separate width function.
  - the priv reset constant.
- One sub-module: ibex_event_rec_fifo, a generic sync FIFO with:
  - push/pop/clear.
  - full/empty/level outputs.
  - no drop logic, which stays in the top.
- Top contains: timestamp, edge/change detect, record assembly, drop counter, lost flag.

Test Plan:
- Single ecall_i pulse in cycle with ts=5, priv=M, FIFO empty, ready=0 -> next cycle rec_valid_o=1, rec_o={lost0, priv3, mask 0x02, ts 5}, level=1.
- core_sleep_i 0->1 at ts=10, 1->0 at ts=20 -> two records: mask 0x40 with ts 10, then mask 0x80 with ts 20.
- priv_mode_i M->U with no events -> record with mask 0x00 and priv=0. Holding U produces no further records.
- Depth=8, ready=0, 10 wfi pulses -> level=8, drop_cnt_o=2. After draining, next wfi record has lost=1 and the one after has lost=0.
- FIFO full, ready=1 and illegal pulse in same cycle -> push accepted, level stays 8, drop_cnt unchanged.
- 4 records queued, rst_ni asserted mid-drain -> outputs zero immediately (async). After release, clear_i with a same-cycle push -> level=0, no record.

Source files
------------

// File: rtl/ibex_event_rec_pkg.sv
// Shared definitions for the core event recorder: event bit positions,
// record layout and the privilege level the recorder resets to.
package ibex_event_rec_pkg;

    localparam int EV_ILLEGAL     = 0;
    localparam int EV_ECALL       = 1;
    localparam int EV_WFI         = 2;
    localparam int EV_EBREAK      = 3;
    localparam int EV_DRET        = 4;
    localparam int EV_MRET        = 5;
    localparam int EV_SLEEP_ENTRY = 6;
    localparam int EV_SLEEP_EXIT  = 7;
    localparam int EV_W           = 8;

    localparam int TS_W_DEFAULT = 16;

    localparam logic [1:0] PRIV_LVL_M = 2'b11;
    localparam logic [1:0] PRIV_LVL_U = 2'b00;

    // Layout at the default timestamp width; other widths use event_rec_width().
    typedef struct packed {
        logic                    lost;
        logic [1:0]              priv;
        logic [EV_W-1:0]         mask;
        logic [TS_W_DEFAULT-1:0] ts;
    } event_rec_t;

    function automatic int unsigned event_rec_width(input int unsigned ts_w);
        return 1 + 2 + EV_W + ts_w;
    endfunction

endpackage

// File: rtl/ibex_event_rec_fifo.sv
// Generic synchronous FIFO with separately tracked level; clear beats push/pop.
// A push while full is accepted only when a pop happens in the same cycle.
module ibex_event_rec_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 27
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LvlW'(Depth));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the read port is forced to zero whenever empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/ibex_core_event_recorder.sv
// Turns per-cycle core event pulses into timestamped records, buffers them and
// streams them out; overflow is counted and flagged on the next accepted record.
module ibex_core_event_recorder import ibex_event_rec_pkg::*; #(
    parameter int unsigned Depth = 8,
    parameter int unsigned TsW   = 16,
    parameter int unsigned DropW = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                enable_i,
    input  logic                                clear_i,
    input  logic                                illegal_instr_i,
    input  logic                                ecall_i,
    input  logic                                wfi_i,
    input  logic                                ebreak_i,
    input  logic                                dret_i,
    input  logic                                mret_i,
    input  logic                                core_sleep_i,
    input  logic [1:0]                          priv_mode_i,
    output logic                                rec_valid_o,
    input  logic                                rec_ready_i,
    output logic [event_rec_width(TsW)-1:0]     rec_o,
    output logic [DropW-1:0]                    drop_cnt_o,
    output logic [$clog2(Depth):0]              fifo_level_o
);

    localparam int unsigned RecW = event_rec_width(TsW);

    logic [TsW-1:0]   ts_q, ts_d;
    logic             sleep_q, sleep_d;
    logic [1:0]       priv_q, priv_d;
    logic             lost_q, lost_d;
    logic [DropW-1:0] drop_cnt_q, drop_cnt_d;

    logic [EV_W-1:0]  ev_mask;
    logic [RecW-1:0]  rec_new;
    logic             push_req, pop, accept, drop;
    logic             fifo_full, fifo_empty;

    always_comb begin
        ev_mask                 = '0;
        ev_mask[EV_ILLEGAL]     = illegal_instr_i;
        ev_mask[EV_ECALL]       = ecall_i;
        ev_mask[EV_WFI]         = wfi_i;
        ev_mask[EV_EBREAK]      = ebreak_i;
        ev_mask[EV_DRET]        = dret_i;
        ev_mask[EV_MRET]        = mret_i;
        ev_mask[EV_SLEEP_ENTRY] = core_sleep_i & ~sleep_q;
        ev_mask[EV_SLEEP_EXIT]  = ~core_sleep_i & sleep_q;
    end

    assign push_req = enable_i & ((ev_mask != '0) | (priv_mode_i != priv_q));
    assign pop      = rec_valid_o & rec_ready_i;
    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign accept   = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;
    assign rec_new  = {lost_q, priv_mode_i, ev_mask, ts_q};

    always_comb begin
        ts_d       = ts_q + TsW'(1);
        sleep_d    = core_sleep_i;
        priv_d     = priv_mode_i;
        lost_d     = lost_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            ts_d       = '0;
            sleep_d    = 1'b0;
            priv_d     = PRIV_LVL_M;
            lost_d     = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            lost_d = 1'b1;
            if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + DropW'(1);
        end else if (accept) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            sleep_q    <= 1'b0;
            priv_q     <= PRIV_LVL_M;
            lost_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            sleep_q    <= sleep_d;
            priv_q     <= priv_d;
            lost_q     <= lost_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ibex_event_rec_fifo #(
        .Depth (Depth),
        .Width (RecW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (accept),
        .wdata_i (rec_new),
        .pop_i   (pop),
        .rdata_o (rec_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign rec_valid_o = ~fifo_empty;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_ibex_core_event_recorder.sv
// Bench for the core event recorder: a hand-computed vector table, directed
// overflow/reset sequences and random traffic against a queue-based model.
module tb_ibex_core_event_recorder;
    import ibex_event_rec_pkg::*;

    localparam int DEPTH = 8;
    localparam int TSW   = 16;
    localparam int DROPW = 8;
    localparam int RECW  = 27;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable_i, clear_i;
    logic            illegal_i, ecall_i, wfi_i, ebreak_i, dret_i, mret_i;
    logic            core_sleep_i;
    logic [1:0]      priv_mode_i;
    logic            rec_valid_o, rec_ready_i;
    logic [RECW-1:0] rec_o;
    logic [DROPW-1:0] drop_cnt_o;
    logic [3:0]      fifo_level_o;

    always #5 clk = ~clk;

    ibex_core_event_recorder #(.Depth(DEPTH), .TsW(TSW), .DropW(DROPW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (enable_i),
        .clear_i         (clear_i),
        .illegal_instr_i (illegal_i),
        .ecall_i         (ecall_i),
        .wfi_i           (wfi_i),
        .ebreak_i        (ebreak_i),
        .dret_i          (dret_i),
        .mret_i          (mret_i),
        .core_sleep_i    (core_sleep_i),
        .priv_mode_i     (priv_mode_i),
        .rec_valid_o     (rec_valid_o),
        .rec_ready_i     (rec_ready_i),
        .rec_o           (rec_o),
        .drop_cnt_o      (drop_cnt_o),
        .fifo_level_o    (fifo_level_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole records plus the recorder's bookkeeping.
    event_rec_t  mq[$];
    int          m_drop;
    logic        m_lost;
    logic [15:0] m_ts;
    logic        m_sleep;
    logic [1:0]  m_priv;

    task automatic model_reset();
        mq.delete();
        m_drop  = 0;
        m_lost  = 1'b0;
        m_ts    = 16'd0;
        m_sleep = 1'b0;
        m_priv  = 2'b11;
    endtask

    task automatic model_step();
        logic [7:0] mask;
        bit         req, pop, acc;
        event_rec_t r;
        if (clear_i) begin
            model_reset();
            return;
        end
        mask = {~core_sleep_i & m_sleep, core_sleep_i & ~m_sleep,
                mret_i, dret_i, ebreak_i, wfi_i, ecall_i, illegal_i};
        req = enable_i && (mask != 8'h00 || priv_mode_i != m_priv);
        pop = (mq.size() > 0) && rec_ready_i;
        acc = 1'b0;
        if (req) begin
            if (mq.size() < DEPTH || pop) begin
                acc    = 1'b1;
                r.lost = m_lost;
                r.priv = priv_mode_i;
                r.mask = mask;
                r.ts   = m_ts;
                m_lost = 1'b0;
            end else begin
                if (m_drop < 255) m_drop++;
                m_lost = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(r);
        m_ts    = m_ts + 16'd1;
        m_sleep = core_sleep_i;
        m_priv  = priv_mode_i;
    endtask

    task automatic check_model();
        event_rec_t head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("mdl_valid", 64'(rec_valid_o), 64'(mq.size() > 0));
        chk("mdl_rec",   64'(rec_o),       64'(head));
        chk("mdl_level", 64'(fifo_level_o), 64'(mq.size()));
        chk("mdl_drop",  64'(drop_cnt_o),  64'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic event_rec_t mk_rec(input logic lost, input logic [1:0] priv,
                                          input logic [7:0] mask, input logic [15:0] ts);
        event_rec_t r;
        r.lost = lost;
        r.priv = priv;
        r.mask = mask;
        r.ts   = ts;
        return r;
    endfunction

    typedef struct {
        logic            ecall;
        logic            sleep;
        logic [1:0]      priv;
        logic            ready;
        logic            chk;
        logic            exp_valid;
        logic [RECW-1:0] exp_rec;
        int              exp_level;
    } vec_t;

    vec_t vecs[27];

    initial begin
        // Table entry k is the cycle whose timestamp is k after reset release.
        for (int k = 0; k < 27; k++) begin
            vecs[k].ecall     = 1'b0;
            vecs[k].sleep     = (k >= 10 && k <= 19);
            vecs[k].priv      = (k >= 23) ? 2'b00 : 2'b11;
            vecs[k].ready     = 1'b0;
            vecs[k].chk       = 1'b0;
            vecs[k].exp_valid = 1'b0;
            vecs[k].exp_rec   = '0;
            vecs[k].exp_level = 0;
        end
        vecs[5].ecall = 1'b1;
        vecs[5].chk = 1'b1; vecs[5].exp_valid = 1'b1; vecs[5].exp_level = 1;
        vecs[5].exp_rec = mk_rec(1'b0, 2'b11, 8'h02, 16'd5);
        vecs[6].ready = 1'b1; vecs[6].chk = 1'b1;
        vecs[10].chk = 1'b1; vecs[10].exp_valid = 1'b1; vecs[10].exp_level = 1;
        vecs[10].exp_rec = mk_rec(1'b0, 2'b11, 8'h40, 16'd10);
        vecs[20].chk = 1'b1; vecs[20].exp_valid = 1'b1; vecs[20].exp_level = 2;
        vecs[20].exp_rec = mk_rec(1'b0, 2'b11, 8'h40, 16'd10);
        vecs[21].ready = 1'b1;
        vecs[21].chk = 1'b1; vecs[21].exp_valid = 1'b1; vecs[21].exp_level = 1;
        vecs[21].exp_rec = mk_rec(1'b0, 2'b11, 8'h80, 16'd20);
        vecs[22].ready = 1'b1; vecs[22].chk = 1'b1;
        vecs[23].chk = 1'b1; vecs[23].exp_valid = 1'b1; vecs[23].exp_level = 1;
        vecs[23].exp_rec = mk_rec(1'b0, 2'b00, 8'h00, 16'd23);
        vecs[25].chk = 1'b1; vecs[25].exp_valid = 1'b1; vecs[25].exp_level = 1;
        vecs[25].exp_rec = mk_rec(1'b0, 2'b00, 8'h00, 16'd23);
        vecs[26].ready = 1'b1; vecs[26].chk = 1'b1;

        enable_i = 1'b1; clear_i = 1'b0;
        illegal_i = 1'b0; ecall_i = 1'b0; wfi_i = 1'b0;
        ebreak_i = 1'b0; dret_i = 1'b0; mret_i = 1'b0;
        core_sleep_i = 1'b0; priv_mode_i = 2'b11; rec_ready_i = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rec_valid_o), 64'(0));
        chk("rst_rec",   64'(rec_o), 64'(0));
        chk("rst_level", 64'(fifo_level_o), 64'(0));
        chk("rst_drop",  64'(drop_cnt_o), 64'(0));
        rst_n = 1'b1;

        for (int k = 0; k < 27; k++) begin
            ecall_i      = vecs[k].ecall;
            core_sleep_i = vecs[k].sleep;
            priv_mode_i  = vecs[k].priv;
            rec_ready_i  = vecs[k].ready;
            tick();
            if (vecs[k].chk) begin
                chk($sformatf("tbl%0d_valid", k), 64'(rec_valid_o), 64'(vecs[k].exp_valid));
                chk($sformatf("tbl%0d_rec", k),   64'(rec_o), 64'(vecs[k].exp_rec));
                chk($sformatf("tbl%0d_level", k), 64'(fifo_level_o), 64'(vecs[k].exp_level));
            end
        end
        ecall_i = 1'b0; core_sleep_i = 1'b0;

        priv_mode_i = 2'b11; rec_ready_i = 1'b1;
        repeat (3) tick();
        chk("pre_ovf_level", 64'(fifo_level_o), 64'(0));

        // Overflow: ten back-to-back wfi with no consumer.
        rec_ready_i = 1'b0;
        wfi_i = 1'b1;
        repeat (10) tick();
        wfi_i = 1'b0;
        chk("ovf_level", 64'(fifo_level_o), 64'(8));
        chk("ovf_drop",  64'(drop_cnt_o), 64'(2));
        rec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_q_lost", 64'(rec_o[26]), 64'(0));
            chk("ovf_q_mask", 64'(rec_o[23:16]), 64'(8'h04));
            tick();
        end
        chk("drain_level", 64'(fifo_level_o), 64'(0));
        rec_ready_i = 1'b0; wfi_i = 1'b1;
        tick();
        wfi_i = 1'b0;
        chk("after_loss_lost", 64'(rec_o[26]), 64'(1));
        chk("after_loss_mask", 64'(rec_o[23:16]), 64'(8'h04));
        chk("after_loss_drop", 64'(drop_cnt_o), 64'(2));
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0; wfi_i = 1'b1;
        tick();
        wfi_i = 1'b0;
        chk("next_lost", 64'(rec_o[26]), 64'(0));
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;

        // Full FIFO with simultaneous pop and push.
        wfi_i = 1'b1;
        repeat (8) tick();
        wfi_i = 1'b0;
        chk("full_level", 64'(fifo_level_o), 64'(8));
        illegal_i = 1'b1; rec_ready_i = 1'b1;
        tick();
        illegal_i = 1'b0; rec_ready_i = 1'b0;
        chk("fullpop_level", 64'(fifo_level_o), 64'(8));
        chk("fullpop_drop",  64'(drop_cnt_o), 64'(2));

        // Asynchronous reset mid-drain.
        rec_ready_i = 1'b1;
        repeat (4) tick();
        rec_ready_i = 1'b0;
        chk("mid_level", 64'(fifo_level_o), 64'(4));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(rec_valid_o), 64'(0));
        chk("arst_rec",   64'(rec_o), 64'(0));
        chk("arst_level", 64'(fifo_level_o), 64'(0));
        chk("arst_drop",  64'(drop_cnt_o), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_i = 1'b1; ecall_i = 1'b1;
        tick();
        clear_i = 1'b0; ecall_i = 1'b0;
        chk("clr_push_level", 64'(fifo_level_o), 64'(0));
        chk("clr_push_valid", 64'(rec_valid_o), 64'(0));
        ecall_i = 1'b1;
        tick();
        ecall_i = 1'b0;
        chk("clr_ts_rec", 64'(rec_o), 64'(mk_rec(1'b0, 2'b11, 8'h02, 16'd0)));

        // Drop counter saturation, then clear.
        wfi_i = 1'b1;
        repeat (270) tick();
        wfi_i = 1'b0;
        chk("sat_drop", 64'(drop_cnt_o), 64'(8'hFF));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("sat_clr_drop",  64'(drop_cnt_o), 64'(0));
        chk("sat_clr_level", 64'(fifo_level_o), 64'(0));

        // Disabled: no records, and no spurious record on re-enable.
        enable_i = 1'b0; priv_mode_i = 2'b00; wfi_i = 1'b1;
        tick();
        wfi_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        chk("dis_level", 64'(fifo_level_o), 64'(0));
        priv_mode_i = 2'b11;
        tick();

        for (int n = 0; n < 3000; n++) begin
            enable_i     = ($urandom_range(0, 9) != 0);
            clear_i      = ($urandom_range(0, 149) == 0);
            illegal_i    = ($urandom_range(0, 7) == 0);
            ecall_i      = ($urandom_range(0, 7) == 0);
            wfi_i        = ($urandom_range(0, 7) == 0);
            ebreak_i     = ($urandom_range(0, 9) == 0);
            dret_i       = ($urandom_range(0, 9) == 0);
            mret_i       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) core_sleep_i = ~core_sleep_i;
            if ($urandom_range(0, 9) == 0) priv_mode_i = 2'($urandom_range(0, 3));
            rec_ready_i  = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                : ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
